// File: rtl/nes_pad_responder_if.sv
// Host-side NES pad bus: latch and shift clock from the host, serial data back.
// The host (poller) uses the master modport, the pad responder uses slave.
interface nes_pad_responder_if;
    logic nes_latch;
    logic nes_clk;
    logic controller_data;

    modport master (
        output nes_latch,
        output nes_clk,
        input  controller_data
    );

    modport slave (
        input  nes_latch,
        input  nes_clk,
        output controller_data
    );
endinterface

// File: rtl/nes_pad_responder.sv
// NES controller responder: serializes eight active-low buttons to an asynchronous host.
// Define NES_PAD_TURBO_EN to enable turbo masking of A/B.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned TURBO_DIV   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    nes_pad_responder_if.slave   pad,
    input  logic [7:0]           buttons_n,
    input  logic [1:0]           turbo_sel,
    output logic                 frame_done,
    output logic [3:0]           bits_sent
);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t                 state;
    logic [7:0]             shreg;
    logic [15:0]            tmo_cnt;
    logic                   data_q;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_prev;
    logic                   clk_prev;
    logic                   latch_s;
    logic                   clk_s;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   clk_rise;
    logic [7:0]             load;

    always_ff @(posedge clock) begin
        if (reset) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.nes_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], pad.nes_clk};
            latch_prev <= latch_s;
            clk_prev   <= clk_s;
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev;
    assign latch_fall = ~latch_s & latch_prev;
    assign clk_rise   = clk_s & ~clk_prev;

`ifdef NES_PAD_TURBO_EN
    logic [TURBO_DIV:0] turbo_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            turbo_cnt <= '0;
        else if (latch_rise)
            turbo_cnt <= turbo_cnt + 1'b1;
    end

    // Selected buttons read as released during the upper half of the turbo period.
    assign load = turbo_cnt[TURBO_DIV] ? (buttons_n | {6'b0, turbo_sel}) : buttons_n;
`else
    logic unused_turbo;
    assign unused_turbo = ^{turbo_sel, 1'(TURBO_DIV)};
    assign load         = buttons_n;
`endif

    // data_q is updated alongside shreg so the output stays registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '1;
            tmo_cnt    <= '0;
            data_q     <= 1'b1;
            frame_done <= 1'b0;
            bits_sent  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (latch_rise) begin
                state     <= LATCH;
                shreg     <= load;
                data_q    <= load[0];
                bits_sent <= '0;
            end else begin
                case (state)
                    IDLE: data_q <= 1'b1;
                    LATCH: begin
                        shreg     <= load;
                        data_q    <= load[0];
                        bits_sent <= '0;
                        if (latch_fall) begin
                            state   <= SHIFT;
                            tmo_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        if (clk_rise && !latch_s) begin
                            shreg     <= {1'b1, shreg[7:1]};
                            bits_sent <= bits_sent + 4'd1;
                            tmo_cnt   <= '0;
                            if (bits_sent == 4'd7) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                                data_q     <= 1'b1;
                            end else begin
                                data_q <= shreg[1];
                            end
                        end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                            state  <= IDLE;
                            data_q <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    DONE: data_q <= 1'b1;
                    default: begin
                        state  <= IDLE;
                        data_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pad.controller_data = data_q;

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Device-side NES controller emulator: presents eight active-low Gameboy/NES button levels on the NES serial pad protocol to an external host that drives latch and clock. It implements the responder end of the same latch/clock/data interface the joypad poller uses as initiator, and serves as a bench partner and bridge for that poller. The host signals are asynchronous to `clock`. They are synchronized, edge-detected, and shifted out one bit per host clock rising edge in A, B, Select, Start, Up, Down, Left, Right order.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `nes_latch` and `nes_clk`; minimum 2.
- `TIMEOUT`, 4096: `clock` cycles without a host edge in SHIFT before the frame is abandoned; 16-bit counter.
- `TURBO_DIV`, 2: turbo toggles every 2^`TURBO_DIV` latched frames; used only under `NES_PAD_TURBO_EN`.
- `clock` in 1: system clock; all state is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `nes_latch` in 1: host strobe, asynchronous, active-high.
- `nes_clk` in 1: host shift clock, asynchronous; shifts on its rising edge.
- `buttons_n` in 8: button levels, 0 = pressed; bit0 A, 1 B, 2 Sel, 3 Start, 4 Up, 5 Dn, 6 L, 7 R.
- `turbo_sel` in 2: bit0 enables turbo A, bit1 enables turbo B; ignored without the macro.
- `controller_data` out 1: serial data to host, registered; 1 = released.
- `frame_done` out 1: one-cycle pulse when the 8th bit has been shifted.
- `bits_sent` out 4: number of shifts in the current frame, 0..8, saturating.

## Operation
- Synchronize both host inputs through `SYNC_STAGES` flops, then a registered previous-value flop. `latch_rise`, `latch_fall` and `clk_rise` are single-cycle pulses.
- `shreg[7:0]` is the shift register. `controller_data` is `shreg[0]` in LATCH and SHIFT, and is forced to 1 in IDLE and DONE.
- IDLE: `controller_data`=1. On `latch_rise`, go to LATCH.
- LATCH: load `shreg` from `buttons_n` (after the turbo mask) every cycle. This is transparent, so `controller_data` follows A while latch is high. Clear `bits_sent`. On `latch_fall`, go to SHIFT and clear the timeout counter.
- SHIFT:
  - On `clk_rise`: `shreg <= {1'b1, shreg[7:1]}`, `bits_sent++`, timeout counter cleared.
  - When `bits_sent` becomes 8, go to DONE and pulse `frame_done` in the same cycle.
  - With no edge, the timeout counter increments. When it reaches `TIMEOUT`, go to IDLE; no `frame_done`.
- DONE: `controller_data`=1. Further `clk_rise` events are ignored and `bits_sent` holds at 8. On `latch_rise`, go to LATCH.
- `latch_rise` in any state goes to LATCH, aborting a partial frame with no `frame_done`.
- `latch_rise` and `clk_rise` in the same cycle: latch wins and the shift is discarded.
- `clk_rise` while the synchronized latch is high: ignored.
- `buttons_n` changes after `latch_fall` do not affect the frame in progress.

## Timing
- Reset values: `controller_data`=1, `frame_done`=0, `bits_sent`=0, state IDLE, `shreg`=8'hFF, timeout counter 0, turbo frame counter 0.
- Host edge to `controller_data` update: `SYNC_STAGES`+1 `clock` cycles (3 at default).
- In LATCH, a `buttons_n` change appears on `controller_data` 1 cycle later.
- `frame_done` asserts in the cycle `bits_sent` becomes 8, and for exactly 1 cycle.
- Host requirement: latch high and each `nes_clk` phase must last at least `SYNC_STAGES`+2 `clock` cycles. Narrower pulses may be missed; the block must not lock up when that happens.
- `reset` mid-frame: next cycle, all outputs take their reset values and the state is IDLE.

## Configuration
- `NES_PAD_TURBO_EN` defined:
  - A `TURBO_DIV`+1-bit frame counter increments on each `latch_rise` and wraps.
  - While its MSB is 1, a button selected by `turbo_sel` is forced to released (1) in the LATCH load. While the MSB is 0, the button passes through.
- `NES_PAD_TURBO_EN` undefined: no frame counter, `turbo_sel` unused, and the load is `buttons_n` unmodified.

## Test plan
- Full frame: `buttons_n`=8'b1111_1010 (A, Sel pressed), latch pulse, then 8 `nes_clk` pulses -> bits sampled before each clock read 0,1,0,1,1,1,1,1; `frame_done` pulses once and `bits_sent`=8.
- Overclock: 12 clock pulses after latch -> `controller_data`=1 for pulses 9-12, `bits_sent` stays 8, and only one `frame_done` pulse.
- Abort: latch again after 3 clocks -> no `frame_done`, `bits_sent`=0, and `controller_data` equals the new A.
- Timeout: latch, 2 clocks, then idle `TIMEOUT`+1 cycles -> state IDLE, `controller_data`=1, no `frame_done`.
- Reset at bit 5 -> next cycle `controller_data`=1, `bits_sent`=0.
- With `NES_PAD_TURBO_EN`, `TURBO_DIV`=2, `turbo_sel`=2'b01, A held pressed -> A reads 0 for 4 frames, then 1 for 4 frames, repeating.
